// File: rtl/parity_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : parity_stream_checker
//  Description : Streaming parity checker. Folds the parity of every beat of a
//                valid/ready packet into an accumulator, seeded with the
//                parity mode latched on the first beat. On the last beat it
//                compares the result with the sender's parity bit. It emits
//                one registered result per packet and keeps a saturating
//                count of mismatching packets.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst        in   synchronous active-high reset
//    in_valid   in   beat valid
//    in_ready   out  beat accepted when in_valid & in_ready
//    in_data    in   [DATA_W-1:0] beat payload
//    in_last    in   final beat of packet
//    in_par     in   sender parity bit (used on the last beat only)
//    odd_mode   in   0 = even, 1 = odd parity (latched on the first beat)
//    out_valid  out  result valid, held until out_ready
//    out_ready  in   result consumed when out_valid & out_ready
//    out_par    out  computed parity bit
//    out_err    out  computed parity differs from in_par
//    out_len    out  [LEN_W-1:0] beats in packet, saturating
//    err_cnt    out  [CNT_W-1:0] mismatching packets, saturating
//    clr_cnt    in   synchronous clear of err_cnt (wins over increment)
// ============================================================================
module parity_stream_checker #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  input  logic              odd_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err,
  output logic [LEN_W-1:0]  out_len,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr_cnt
);

  // ST_FIRST: the next accepted beat opens a packet.
  // ST_BODY : a packet is in progress.
  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_BODY  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               acc_q, acc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               out_valid_q, out_valid_d;
  logic               out_par_q, out_par_d;
  logic               out_err_q, out_err_d;
  logic [LEN_W-1:0]   out_len_q, out_len_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               w_wp;
  logic               w_acc_fire;
  logic               w_acc_n;
  logic [LEN_W-1:0]   w_len_n;
  logic               w_mismatch;

  assign w_wp       = ^in_data;
  // The result register may be refilled in the same cycle it drains, so a
  // full output only stalls the input when the consumer is not taking it.
  assign in_ready   = ~out_valid_q | out_ready;
  assign w_acc_fire = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_par_d   = out_par_q;
    out_err_d   = out_err_q;
    out_len_d   = out_len_q;
    err_cnt_d   = err_cnt_q;

    // The first beat seeds the accumulator with the mode, so later changes
    // of odd_mode cannot affect a packet already in progress.
    if (state_q == ST_FIRST) begin
      w_acc_n = odd_mode ^ w_wp;
      w_len_n = LEN_W'(1);
    end else begin
      w_acc_n = acc_q ^ w_wp;
      w_len_n = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
    end
    w_mismatch = w_acc_n ^ in_par;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_acc_fire) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_par_d   = w_acc_n;
        out_err_d   = w_mismatch;
        out_len_d   = w_len_n;
        state_d     = ST_FIRST;
        acc_d       = 1'b0;
        len_d       = '0;
      end else begin
        state_d     = ST_BODY;
        acc_d       = w_acc_n;
        len_d       = w_len_n;
      end
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (w_acc_fire && in_last && w_mismatch &&
                 (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FIRST;
      acc_q       <= 1'b0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_len_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_par_q   <= out_par_d;
      out_err_q   <= out_err_d;
      out_len_q   <= out_len_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign out_len   = out_len_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_stream_checker
//  Description : Bench for parity_stream_checker. Two instances share one
//                stimulus stream: a wide one (LEN_W=8, CNT_W=8) and a narrow
//                one (LEN_W=2, CNT_W=2) that exercises saturation. Expected
//                results come from a packet-level model that counts ones and
//                beats per packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_par;
  logic        odd_mode;
  logic        out_ready;
  logic        clr_cnt;

  logic        a_in_ready, a_out_valid, a_out_par, a_out_err;
  logic [7:0]  a_out_len, a_err_cnt;
  logic        b_in_ready, b_out_valid, b_out_par, b_out_err;
  logic [1:0]  b_out_len, b_err_cnt;

  always #5 clk = ~clk;

  parity_stream_checker #(.DATA_W(16), .LEN_W(8), .CNT_W(8)) u_wide (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .in_par(in_par), .odd_mode(odd_mode),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_par(a_out_par),
    .out_err(a_out_err), .out_len(a_out_len), .err_cnt(a_err_cnt),
    .clr_cnt(clr_cnt)
  );

  parity_stream_checker #(.DATA_W(16), .LEN_W(2), .CNT_W(2)) u_narrow (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .in_par(in_par), .odd_mode(odd_mode),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_par(b_out_par),
    .out_err(b_out_err), .out_len(b_out_len), .err_cnt(b_err_cnt),
    .clr_cnt(clr_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Packet-level reference model
  bit m_inpkt, m_mode, m_ov, m_par, m_err;
  int m_ones, m_beats, m_len8, m_len2, m_cnt8, m_cnt2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Model update for one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit ready, load;
    if (rst) begin
      m_inpkt = 0; m_mode = 0; m_ov = 0; m_par = 0; m_err = 0;
      m_ones = 0; m_beats = 0; m_len8 = 0; m_len2 = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    ready = !m_ov || out_ready;
    load  = 0;
    if (in_valid && ready) begin
      if (!m_inpkt) begin
        m_mode  = odd_mode;
        m_ones  = $countones(in_data);
        m_beats = 1;
      end else begin
        m_ones  += $countones(in_data);
        m_beats += 1;
      end
      if (in_last) begin
        load    = 1;
        // even mode: ones+par even; odd mode: ones+par odd
        m_par   = ((m_ones % 2) == 1) ^ m_mode;
        m_err   = m_par ^ in_par;
        m_len8  = sat(m_beats, 255);
        m_len2  = sat(m_beats, 3);
        m_inpkt = 0;
      end else begin
        m_inpkt = 1;
      end
    end
    if (load) m_ov = 1;
    else if (out_ready) m_ov = 0;
    if (clr_cnt) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (load && m_err) begin
      m_cnt8 = sat(m_cnt8 + 1, 255);
      m_cnt2 = sat(m_cnt2 + 1, 3);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) begin
      chk("in_ready_w", 32'(a_in_ready), 32'(!m_ov || out_ready));
      chk("in_ready_n", 32'(b_in_ready), 32'(!m_ov || out_ready));
    end
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid_w", 32'(a_out_valid), 32'(m_ov));
    chk("out_par_w",   32'(a_out_par),   32'(m_par));
    chk("out_err_w",   32'(a_out_err),   32'(m_err));
    chk("out_len_w",   32'(a_out_len),   32'(m_len8));
    chk("err_cnt_w",   32'(a_err_cnt),   32'(m_cnt8));
    chk("out_valid_n", 32'(b_out_valid), 32'(m_ov));
    chk("out_par_n",   32'(b_out_par),   32'(m_par));
    chk("out_err_n",   32'(b_out_err),   32'(m_err));
    chk("out_len_n",   32'(b_out_len),   32'(m_len2));
    chk("err_cnt_n",   32'(b_err_cnt),   32'(m_cnt2));
  endtask

  task automatic beat(input logic [15:0] d, input bit last, input bit par, input bit mode);
    in_valid = 1; in_data = d; in_last = last; in_par = par; odd_mode = mode;
    step();
  endtask

  task automatic idle();
    in_valid = 0; in_data = 16'hDEAD; in_last = 1; in_par = 1;
    step();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_last = 0; in_par = 0;
    odd_mode = 0; out_ready = 1; clr_cnt = 0;
    step(); step();
    rst = 0;
    idle();

    // Single-beat even packet: par=1 matches in_par=1
    beat(16'h0001, 1, 1, 0);
    chk("single_par", 32'(a_out_par), 32'd1);
    idle();

    // 19 ones, even mode, in_par=0 -> par=1, mismatch
    beat(16'hFFFF, 0, 0, 0);
    beat(16'h0003, 0, 0, 0);
    beat(16'h8000, 1, 0, 0);
    chk("three_beat_err", 32'(a_out_err), 32'd1);
    chk("three_beat_cnt", 32'(a_err_cnt), 32'd1);
    // Same packet, odd mode latched on first beat then dropped
    beat(16'hFFFF, 0, 0, 1);
    beat(16'h0003, 0, 0, 0);
    beat(16'h8000, 1, 0, 0);
    chk("odd_mode_par", 32'(a_out_par), 32'd0);
    idle();

    // Backpressure: result held, waiting packet not consumed
    out_ready = 0;
    beat(16'h00FF, 1, 0, 0);
    for (int i = 0; i < 5; i++) beat(16'h0001, 1, 0, 0);
    out_ready = 1;
    beat(16'h0001, 1, 0, 0);  // drain and reload in one cycle
    chk("reload_valid", 32'(a_out_valid), 32'd1);
    idle();

    // Counter saturation on the narrow instance, then clear vs increment
    clr_cnt = 1; idle(); clr_cnt = 0;
    for (int i = 0; i < 5; i++) beat(16'h0001, 1, 0, 0);
    chk("cnt2_sat", 32'(b_err_cnt), 32'd3);
    clr_cnt = 1;
    beat(16'h0001, 1, 0, 0);
    clr_cnt = 0;
    chk("clr_priority", 32'(b_err_cnt), 32'd0);
    idle();

    // Reset mid-packet
    beat(16'h1234, 0, 0, 0);
    beat(16'h0F0F, 0, 0, 0);
    rst = 1; idle(); rst = 0;
    chk("rst_valid", 32'(a_out_valid), 32'd0);
    beat(16'h0000, 1, 0, 0);
    chk("post_rst_len", 32'(a_out_len), 32'd1);
    idle();

    // Six-beat zero packet: narrow length saturates at 3
    for (int i = 0; i < 6; i++) beat(16'h0000, i == 5, 0, 0);
    chk("len2_sat", 32'(b_out_len), 32'd3);
    idle();

    // Random traffic with random backpressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      in_par    = 1'($urandom);
      odd_mode  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; clr_cnt = 0; out_ready = 1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
